sram_line_fetcher: RTL and testbench
====================================

Name: sram_line_fetcher

Overview:
Read-side requester that sits directly upstream of the SRAM arbiter's VGA request port. On a start pulse it issues `count` single-word reads from consecutive SRAM addresses. It captures each returned word into a show-ahead FIFO that the VGA pixel pipeline drains. It releases the arbiter between reads so renderer writes are never starved.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 32, SRAM data width
CNT_W, 8, width of burst word count
DEPTH, 16, FIFO depth in words (power of two, >=2)
GAP_CYCLES, 1, idle cycles forced between consecutive reads (0 allowed)

Ports:
clk  in  1  system clock (25 MHz domain of the SRAM arbiter)
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle burst start pulse
base_addr  in  ADDR_W  first word address, sampled with start
count  in  CNT_W  words in burst, sampled with start
flush  in  1  abort burst and empty FIFO
busy  out  1  burst in progress
req_address  out  ADDR_W  read address to arbiter
req_oe_n  out  1  read request, active low
req_we_n  out  1  tied 1
req_den  out  1  tied 0
sram_done  in  1  arbiter grant pulse
sram_din  in  DATA_W  SRAM read data from arbiter
out_valid  out  1  FIFO non-empty
out_data  out  DATA_W  FIFO head word
out_ready  in  1  pop FIFO head when out_valid
fifo_level  out  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low, async): FSM in IDLE; FIFO empty; busy=0, out_valid=0, fifo_level=0, req_oe_n=1, req_address=0, out_data=0.
- FSM states:
  - IDLE: start with count!=0 latches addr=base_addr and remaining=count, then goes to REQ. start with count==0 is ignored.
  - REQ: waits for a grant (see request rule).
  - GAP: counts GAP_CYCLES, then goes to WAIT_SPACE.
  - WAIT_SPACE: goes to REQ when fifo_level<DEPTH.
  - FLUSH: lasts exactly one cycle, then goes to IDLE.
- Request rule: req_oe_n = !(state==REQ && !sram_done). It is combinational so it rises in the grant cycle and the arbiter never double-issues. req_address = addr, registered.
- Entry into REQ requires fifo_level<DEPTH at the transition; otherwise the FSM goes through WAIT_SPACE. At most one read is outstanding.
- Capture: at the rising edge where state==REQ and sram_done==1:
  - push sram_din into the FIFO;
  - addr<=addr+1, wrapping modulo 2^ADDR_W;
  - remaining<=remaining-1;
  - next state is IDLE if remaining==1, else GAP (or WAIT_SPACE directly when GAP_CYCLES==0).
- sram_done outside REQ is ignored.
- Latency: start accepted at edge E0, arbiter latches at E1, data captured at E2, out_valid=1 after E2 (empty FIFO).
- Throughput: one word per 2+GAP_CYCLES cycles when the arbiter is free. Renderer stalls extend REQ indefinitely, with no timeout.
- busy = (state!=IDLE).
- start while busy is ignored.
- FIFO:
  - Show-ahead: out_data is valid whenever out_valid=1.
  - Pop when out_valid && out_ready; pop when empty is ignored.
  - Simultaneous push and pop leaves the level unchanged (legal when full, since a push is only possible after space was checked).
  - Overflow is impossible by construction.
- flush (synchronous, highest priority over start and capture):
  - FIFO is emptied next edge and the FSM goes to FLUSH.
  - A grant pulse arriving during FLUSH is discarded; a capture coinciding with flush is discarded.
  - start is ignored during FLUSH.
  - flush in IDLE still empties the FIFO.
- Reset mid-burst aborts immediately with no outstanding-read bookkeeping.

Test Plan:
- Basic burst: base_addr=0x00100, count=4, arbiter grants every request one cycle later, out_ready=1 -> addresses 0x00100..0x00103 issued, 4 words delivered in order, busy falls after 4th capture, req_oe_n high at least GAP_CYCLES+1 cycles between reads.
- Backpressure: DEPTH=16, count=20, out_ready=0 -> exactly 16 reads issued, FSM parks in WAIT_SPACE, fifo_level=16. Raising out_ready resumes the last 4 reads, and all 20 words are received in order.
- Arbiter stall: sram_done held low 10 cycles in REQ -> req_oe_n stays low, address stable, no capture. The grant then yields exactly one push.
- Address wrap and edge counts: base_addr=0xFFFFE, count=3 -> addresses 0xFFFFE, 0xFFFFF, 0x00000. count=0 start -> busy stays 0, no request. start while busy -> no effect.
- Flush race: flush asserted in the same cycle req_oe_n is sampled low, then start the cycle after FLUSH -> stale grant ignored, FIFO empty, new burst data only.
- Async reset mid-burst: rst_n pulsed low mid-cycle during REQ with 5 words buffered -> outputs immediately at reset values, req_oe_n=1.

Source files
------------

// File: rtl/sram_line_fetcher.sv
// rtl/sram_line_fetcher.sv - burst SRAM reader feeding a show-ahead FIFO for the VGA pipeline
module sram_line_fetcher #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 8,
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 1,
    localparam int LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              flush,
    output logic              busy,
    output logic [ADDR_W-1:0] req_address,
    output logic              req_oe_n,
    output logic              req_we_n,
    output logic              req_den,
    input  logic              sram_done,
    input  logic [DATA_W-1:0] sram_din,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  fifo_level
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_remaining;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_push;
    logic              w_pop;
    logic              w_accept;
    logic              w_space;
    logic [LVL_W-1:0]  w_level_nxt;
    logic [2:0]        w_state_nxt;

    assign w_push   = (r_state == S_REQ) && sram_done && !flush;
    assign w_pop    = (r_level != '0) && out_ready && !flush;
    assign w_accept = (r_state == S_IDLE) && start && (count != '0) && !flush;

    always_comb begin
        w_level_nxt = r_level;
        if (flush)
            w_level_nxt = '0;
        else
            w_level_nxt = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    end

    // Space is judged on the post-edge level so a REQ entry can never overflow.
    assign w_space = (w_level_nxt < LVL_W'(DEPTH));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && (count != '0))
                    w_state_nxt = w_space ? S_REQ : S_WAIT;
            end
            S_REQ: begin
                if (sram_done) begin
                    if (r_remaining == CNT_W'(1))
                        w_state_nxt = S_IDLE;
                    else if (GAP_CYCLES > 0)
                        w_state_nxt = S_GAP;
                    else
                        w_state_nxt = w_space ? S_REQ : S_WAIT;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0)
                    w_state_nxt = w_space ? S_REQ : S_WAIT;
            end
            S_WAIT: begin
                if (w_space)
                    w_state_nxt = S_REQ;
            end
            S_FLUSH: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush)
            w_state_nxt = S_FLUSH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_gap_cnt   <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_accept) begin
                r_addr      <= base_addr;
                r_remaining <= count;
            end else if (w_push) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - CNT_W'(1);
            end
            if (w_push)
                r_gap_cnt <= GAP_W'(GAP_LOAD);
            else if ((r_state == S_GAP) && (r_gap_cnt != '0))
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= sram_din;
    end

    // Request drops in the grant cycle itself so the arbiter never sees a second request.
    assign req_oe_n    = !((r_state == S_REQ) && !sram_done);
    assign req_address = r_addr;
    assign req_we_n    = 1'b1;
    assign req_den     = 1'b0;
    assign busy        = (r_state != S_IDLE);
    assign out_valid   = (r_level != '0);
    assign out_data    = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
    assign fifo_level  = r_level;

endmodule

// File: tb/tb_sram_line_fetcher.sv
// tb/tb_sram_line_fetcher.sv - self-checking bench for sram_line_fetcher
module tb_sram_line_fetcher;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;
    localparam int DEPTH  = 16;
    localparam int GAP    = 1;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  count;
    logic              flush;
    logic              busy;
    logic [ADDR_W-1:0] req_address;
    logic              req_oe_n;
    logic              req_we_n;
    logic              req_den;
    logic              sram_done;
    logic [DATA_W-1:0] sram_din;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [LVL_W-1:0]  fifo_level;

    sram_line_fetcher #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W),
        .DEPTH(DEPTH), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .count(count), .flush(flush), .busy(busy), .req_address(req_address),
        .req_oe_n(req_oe_n), .req_we_n(req_we_n), .req_den(req_den),
        .sram_done(sram_done), .sram_din(sram_din), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .fifo_level(fifo_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return {12'hA5C, a};
    endfunction

    // Model: FIFO contents, burst progress, and the arbiter's view of the one outstanding read.
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] pop_log[$];
    logic [ADDR_W-1:0] grant_log[$];
    int                m_rem    = 0;
    logic [ADDR_W-1:0] m_addr   = '0;
    bit                m_fl     = 0;
    bit                pend     = 0;
    bit                killed   = 0;
    logic [ADDR_W-1:0] pend_addr = '0;
    int                stall    = 0;
    bit                track    = 0;
    int                hi_run   = 0;

    // Arbiter: grants the latched request one cycle later, optionally after a stall.
    initial begin
        sram_done = 1'b0;
        sram_din  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && pend && stall > 0) begin
                stall--;
                sram_done = 1'b0;
            end else if (rst_n && pend) begin
                sram_done = 1'b1;
                sram_din  = word_of(pend_addr);
            end else begin
                sram_done = 1'b0;
            end
        end
    end

    initial begin
        bit busy_now;
        bit fl_now;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                fl_now   = m_fl;
                busy_now = (m_rem != 0) || m_fl;
                check("busy", busy, busy_now);
                check("out_valid", out_valid, m_q.size() != 0);
                check("fifo_level", fifo_level, m_q.size());
                if (m_q.size() != 0)
                    check("out_data", out_data, m_q[0]);
                check("req_we_n", req_we_n, 1);
                check("req_den", req_den, 0);
                if (pend && !killed && !sram_done) begin
                    check("stall_oe_n", req_oe_n, 0);
                    check("stall_addr", req_address, pend_addr);
                end
                if (!req_oe_n && !pend) begin
                    check("req_in_burst", m_rem != 0, 1);
                    check("req_address", req_address, m_addr);
                    if (track) begin
                        check("gap_oe_high", hi_run >= GAP + 1, 1);
                        track = 0;
                    end
                    pend      = 1;
                    killed    = 0;
                    pend_addr = req_address;
                end
                if (req_oe_n)
                    hi_run++;
                if (flush) begin
                    m_q.delete();
                    m_rem = 0;
                    m_fl  = 1;
                    track = 0;
                    if (pend && sram_done) pend = 0;
                    else if (pend) killed = 1;
                end else begin
                    m_fl = 0;
                    if (m_q.size() != 0 && out_ready)
                        pop_log.push_back(m_q.pop_front());
                    if (pend && sram_done) begin
                        if (!killed) begin
                            m_q.push_back(word_of(pend_addr));
                            grant_log.push_back(pend_addr);
                            m_addr++;
                            m_rem--;
                            track  = (m_rem != 0);
                            hi_run = 1;
                        end
                        pend   = 0;
                        killed = 0;
                    end
                    if (start && count != 0 && !busy_now && !fl_now) begin
                        m_rem  = int'(count);
                        m_addr = base_addr;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] c);
        start     = 1'b1;
        base_addr = a;
        count     = c;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_quiet(input string name, input int limit);
        int n = 0;
        while (!(m_rem == 0 && !m_fl && !pend && (m_q.size() == 0 || !out_ready)) && n < limit) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, n < limit, 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        int p0;
        int n;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0;
        flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_oe_n", req_oe_n, 1);
        check("rst_addr", req_address, 0);
        check("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        tick();

        // First-word latency with an empty FIFO
        out_ready = 1'b0;
        start = 1'b1; base_addr = 20'h00600; count = 8'd1;
        tick();
        start = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin tick(); n++; end
        check("latency_edges", n, 3);
        out_ready = 1'b1;
        wait_quiet("latency", 50);

        // Basic burst
        g0 = grant_log.size(); p0 = pop_log.size();
        pulse_start(20'h00100, 8'd4);
        wait_quiet("basic", 200);
        check("basic_grants", grant_log.size() - g0, 4);
        check("basic_addr0", grant_log[g0], 20'h00100);
        check("basic_addr3", grant_log[g0 + 3], 20'h00103);
        check("basic_word0", pop_log[p0], 32'hA5C00100);
        check("basic_word3", pop_log[p0 + 3], 32'hA5C00103);
        check("basic_busy", busy, 0);

        // Backpressure
        out_ready = 1'b0;
        g0 = grant_log.size(); p0 = pop_log.size();
        pulse_start(20'h00200, 8'd20);
        repeat (120) tick();
        check("bp_reads", grant_log.size() - g0, 16);
        check("bp_level", fifo_level, 16);
        check("bp_busy", busy, 1);
        check("bp_oe_n", req_oe_n, 1);
        out_ready = 1'b1;
        wait_quiet("bp", 300);
        check("bp_words", pop_log.size() - p0, 20);
        check("bp_word16", pop_log[p0 + 16], 32'hA5C00210);
        check("bp_word19", pop_log[p0 + 19], 32'hA5C00213);

        // Arbiter stall
        g0 = grant_log.size(); p0 = pop_log.size();
        stall = 10;
        pulse_start(20'h00300, 8'd2);
        wait_quiet("stall", 200);
        check("stall_grants", grant_log.size() - g0, 2);
        check("stall_word0", pop_log[p0], 32'hA5C00300);
        check("stall_word1", pop_log[p0 + 1], 32'hA5C00301);

        // Address wrap
        g0 = grant_log.size(); p0 = pop_log.size();
        pulse_start(20'hFFFFE, 8'd3);
        wait_quiet("wrap", 200);
        check("wrap_addr0", grant_log[g0], 20'hFFFFE);
        check("wrap_addr1", grant_log[g0 + 1], 20'hFFFFF);
        check("wrap_addr2", grant_log[g0 + 2], 20'h00000);
        check("wrap_word2", pop_log[p0 + 2], 32'hA5C00000);

        // Zero count
        g0 = grant_log.size();
        pulse_start(20'h00700, 8'd0);
        repeat (10) tick();
        check("zero_grants", grant_log.size() - g0, 0);
        check("zero_busy", busy, 0);

        // Start while busy
        g0 = grant_log.size();
        pulse_start(20'h00400, 8'd2);
        pulse_start(20'h00500, 8'd5);
        wait_quiet("busy_start", 200);
        check("bs_grants", grant_log.size() - g0, 2);
        check("bs_addr1", grant_log[g0 + 1], 20'h00401);

        // Flush race
        out_ready = 1'b0;
        pulse_start(20'h00800, 8'd3);
        wait_quiet("fr_fill", 200);
        check("fr_fill_level", fifo_level, 3);
        g0 = grant_log.size(); p0 = pop_log.size();
        pulse_start(20'h00900, 8'd2);
        flush = 1'b1;
        check("fr_oe_low", req_oe_n, 0);
        tick();
        flush = 1'b0;
        check("fr_flush_level", fifo_level, 0);
        tick();
        pulse_start(20'h00A00, 8'd2);
        out_ready = 1'b1;
        wait_quiet("fr", 200);
        check("fr_words", pop_log.size() - p0, 2);
        check("fr_word0", pop_log[p0], 32'hA5C00A00);
        check("fr_word1", pop_log[p0 + 1], 32'hA5C00A01);
        check("fr_grants", grant_log.size() - g0, 2);

        // Async reset mid-burst
        out_ready = 1'b0;
        pulse_start(20'h00B00, 8'd8);
        n = 0;
        while (!(fifo_level == 5 && !req_oe_n) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rs_reach", n < 100, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_busy", busy, 0);
        check("rs_out_valid", out_valid, 0);
        check("rs_level", fifo_level, 0);
        check("rs_oe_n", req_oe_n, 1);
        check("rs_addr", req_address, 0);
        check("rs_out_data", out_data, 0);
        m_q.delete(); m_rem = 0; m_fl = 0; pend = 0; killed = 0; track = 0; stall = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        p0 = pop_log.size();
        out_ready = 1'b1;
        pulse_start(20'h00C00, 8'd2);
        wait_quiet("recover", 200);
        check("rec_word0", pop_log[p0], 32'hA5C00C00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
